// File: rtl/dram_block_mover.sv
// dram_block_mover: block copy/fill engine driving the DataRAM port, with overlap-safe copy direction.
module dram_block_mover #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Op,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Len,
  input  logic [DW-1:0] FillVal,
  output logic          Busy,
  output logic          Done,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] DataSrc,
  input  logic [DW-1:0] DataMemOut
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, dn_q, dn_d;
  logic [AW-1:0] cnt_q, cnt_d, src_q, src_d, dst_q, dst_d, addr_q, addr_d, diff;
  logic [DW-1:0] fill_q, fill_d, buf_q, buf_d, dsrc_q, dsrc_d;
  logic busy_q, busy_d, done_q, done_d, rd_q, rd_d, wr_q, wr_d, ovl;
  assign diff = DstAddr - SrcAddr;
  // destination lies strictly inside the source window: copy top-down so unread bytes are not clobbered
  assign ovl = (diff != '0) && (diff <= Len - AW'(1));
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    dn_d = dn_q;
    cnt_d = cnt_q;
    src_d = src_q;
    dst_d = dst_q;
    fill_d = fill_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (Start) begin
        op_d = Op;
        fill_d = FillVal;
        cnt_d = Len;
        dn_d = !Op && ovl;
        src_d = dn_d ? SrcAddr + Len - AW'(1) : SrcAddr;
        dst_d = dn_d ? DstAddr + Len - AW'(1) : DstAddr;
        state_d = (Len == '0) ? DONE : Op ? WR : RD;
      end
      RD: begin
        buf_d = DataMemOut;
        state_d = WR;
      end
      WR: begin
        cnt_d = cnt_q - AW'(1);
        src_d = dn_q ? src_q - AW'(1) : src_q + AW'(1);
        dst_d = dn_q ? dst_q - AW'(1) : dst_q + AW'(1);
        state_d = (cnt_q == AW'(1)) ? DONE : op_q ? WR : RD;
      end
      default: state_d = IDLE;
    endcase
    rd_d = state_d == RD;
    wr_d = state_d == WR;
    busy_d = rd_d || wr_d;
    done_d = state_d == DONE;
    addr_d = rd_d ? src_d : wr_d ? dst_d : '0;
    dsrc_d = wr_d ? (op_d ? fill_d : buf_d) : '0;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      dn_q <= 1'b0;
      cnt_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      fill_q <= '0;
      buf_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      dsrc_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      dn_q <= dn_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      dst_q <= dst_d;
      fill_q <= fill_d;
      buf_q <= buf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      dsrc_q <= dsrc_d;
    end
  end
  assign Busy = busy_q;
  assign Done = done_q;
  assign MemRead = rd_q;
  assign MemWrite = wr_q;
  assign Address = addr_q;
  assign DataSrc = dsrc_q;
endmodule

// File: tb/tb_dram_block_mover.sv
// tb_dram_block_mover: directed checks of dram_block_mover against a behavioural DataRAM.
module tb_dram_block_mover;
  logic CLK = 0, Reset = 1, Start = 0, Op = 0;
  logic [7:0] SrcAddr = 0, DstAddr = 0, Len = 0, FillVal = 0;
  logic Busy, Done, MemRead, MemWrite;
  logic [7:0] Address, DataSrc, DataMemOut;
  logic [7:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  int nrd, nwr, nacc, both, dc;
  logic [7:0] a0, a1;
  logic [19:0] rst_out;
  logic post_busy, post_done;

  dram_block_mover #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Len(Len), .FillVal(FillVal), .Busy(Busy), .Done(Done), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .DataSrc(DataSrc), .DataMemOut(DataMemOut)
  );

  always #5 CLK = ~CLK;
  assign DataMemOut = mem[Address];
  always @(posedge CLK) if (MemWrite) mem[Address] <= DataSrc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // poke>0: re-assert Start with other operands in that busy cycle; poke<0: in the DONE cycle
  task automatic go(input logic op, input logic [7:0] src, dst, len, fv, input int poke, input int rst_at);
    Op = op; SrcAddr = src; DstAddr = dst; Len = len; FillVal = fv; Start = 1;
    @(posedge CLK); #1;
    Start = 0; Op = ~op; SrcAddr = 8'h99; DstAddr = 8'h9A; Len = 8'hFF; FillVal = 8'h3C;
    nrd = 0; nwr = 0; nacc = 0; both = 0; dc = 0; a0 = 0; a1 = 0; rst_out = '1;
    for (int c = 1; c <= 1000; c++) begin
      if (MemRead && MemWrite) both++;
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (MemRead || MemWrite) begin
        if (nacc == 0) a0 = Address;
        if (nacc == 1) a1 = Address;
        nacc++;
      end
      if (Done) dc = c;
      if (c == poke || (Done && poke < 0)) Start = 1;
      if (c == rst_at) begin
        Reset = 1;
        @(posedge CLK); #1;
        Reset = 0;
        rst_out = {Busy, Done, MemRead, MemWrite, Address, DataSrc};
        break;
      end
      @(posedge CLK); #1;
      Start = 0;
      if (dc != 0) break;
    end
    post_busy = Busy; post_done = Done;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(posedge CLK);
    #1 Reset = 0;
    chk("reset_outs", {Busy, Done, MemRead, MemWrite, Address, DataSrc}, 0);

    go(1, 8'h00, 8'h10, 8'd4, 8'hA5, 0, 0);
    chk("fill_done_cycle", dc, 5);
    chk("fill_writes", nwr, 4);
    chk("fill_reads", nrd, 0);
    chk("fill_addr", {a0, a1}, 16'h1011);
    chk("fill_mem", {mem[8'h0F], mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13], mem[8'h14]}, 48'h00A5A5A5A500);
    chk("fill_single_done", {post_busy, post_done}, 0);

    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;
    go(0, 8'h20, 8'h40, 8'd3, 8'h00, 0, 0);
    chk("asc_done_cycle", dc, 7);
    chk("asc_rd_wr", {nrd[7:0], nwr[7:0], both[7:0]}, 24'h030300);
    chk("asc_addr", {a0, a1}, 16'h2040);
    chk("asc_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h01020300);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    go(0, 8'h00, 8'h02, 8'd4, 8'h00, 0, 0);
    chk("desc_done_cycle", dc, 9);
    chk("desc_addr", {a0, a1}, 16'h0305);
    chk("desc_mem", {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]}, 48'h112211223344);
    go(0, 8'h02, 8'h00, 8'd4, 8'h00, 0, 0);
    chk("down_asc_addr", {a0, a1}, 16'h0200);
    chk("down_asc_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h11223344);

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    go(1, 8'h00, 8'hFE, 8'd3, 8'h77, 0, 0);
    chk("wrap_done_cycle", dc, 4);
    chk("wrap_mem", {mem[8'hFD], mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 40'h0077777700);

    go(0, 8'h10, 8'h20, 8'd0, 8'h00, 0, 0);
    chk("len0_done_cycle", dc, 1);
    chk("len0_no_access", nacc, 0);
    chk("len0_idle_after", {post_busy, post_done}, 0);

    for (int i = 0; i < 8; i++) mem[8'h80 + i] = 8'(i + 1);
    go(0, 8'h80, 8'h90, 8'd8, 8'h00, 0, 5);
    chk("rst_outs_zero", rst_out, 0);
    chk("rst_partial_mem", {mem[8'h90], mem[8'h91], mem[8'h92]}, 24'h010200);
    go(0, 8'h80, 8'h90, 8'd8, 8'h00, 0, 0);
    chk("after_rst_done_cycle", dc, 17);
    chk("after_rst_mem", {mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93], mem[8'h94], mem[8'h95], mem[8'h96], mem[8'h97]}, 64'h0102030405060708);

    go(1, 8'h00, 8'h30, 8'd4, 8'h5A, 2, 0);
    chk("poke_busy_done_cycle", dc, 5);
    chk("poke_busy_writes", {nrd[7:0], nwr[7:0]}, 16'h0004);
    chk("poke_busy_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33], mem[8'h34]}, 40'h5A5A5A5A00);
    go(1, 8'h00, 8'h38, 8'd2, 8'hC3, -1, 0);
    chk("poke_done_cycle", dc, 3);
    chk("poke_done_ignored", {post_busy, post_done}, 0);
    @(posedge CLK); #1;
    chk("poke_done_still_idle", {Busy, Done, MemRead, MemWrite}, 0);
    chk("poke_done_mem", {mem[8'h38], mem[8'h39], mem[8'h3A]}, 24'hC3C300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
